// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
//   Shared definitions for the nibble-serial add/subtract controller and the
//   4-bit ripple-carry slice it sequences.
//   Contents:
//     NIBBLE  - slice width in bits (one nibble processed per clock)
//     state_e - controller state encoding (IDLE -> RUN -> DONE -> IDLE)
// -----------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : nibble_serial_adder_ctrl_pkg

// File: rtl/ripple_carry_4_bit_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_4_bit_adder
//   Purely combinational 4-bit ripple-carry adder built from full-adder cells.
//   Ports:
//     A  [3:0] in   addend
//     B  [3:0] in   addend
//     C0       in   carry in
//     S  [3:0] out  sum bits
//     C4       out  carry out of bit 3
// -----------------------------------------------------------------------------
module ripple_carry_4_bit_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] A,
  input  logic [NIBBLE-1:0] B,
  input  logic              C0,
  output logic [NIBBLE-1:0] S,
  output logic              C4
);

  logic [NIBBLE:0] c;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here the defaults at the top), otherwise synthesis infers a latch.
  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = C0;
    for (int i = 0; i < NIBBLE; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign C4 = c[NIBBLE];

endmodule : ripple_carry_4_bit_adder

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//   Adds or subtracts two WIDTH-bit operands by stepping a single shared 4-bit
//   ripple-carry slice across them, least-significant nibble first, one nibble
//   per clock. The inter-nibble carry lives in a register.
//   Parameters:
//     WIDTH  operand width; multiple of 4 and >= 8
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   asynchronous active-high reset
//     start  in   request, sampled only in IDLE
//     sub    in   0: a+b+cin, 1: a-b (cin ignored)
//     a, b   in   operands, captured when start is accepted
//     cin    in   carry-in for add mode
//     busy   out  high whenever the controller is not idle
//     done   out  one-cycle pulse, result valid
//     sum    out  result register
//     cout   out  carry out of the MSB nibble (sub: 1 = no borrow)
//     ovf    out  signed overflow of the final result
//   Timing: accept on edge k, done high after edge k+NIB; one operation per
//   NIB+2 cycles when issued back to back.
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_q;       // operand A as captured
  logic [WIDTH-1:0] b_q;       // effective operand B (already inverted for sub)
  logic [IDX_W-1:0] idx_q;     // nibble currently presented to the slice
  logic             carry_q;   // carry chained between nibble steps
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last_step;

  // Slice connections
  logic [NIBBLE-1:0] a_nib;
  logic [NIBBLE-1:0] b_nib;
  logic [NIBBLE-1:0] s_nib;
  logic              c4;
  int unsigned       nib_lsb;

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_step = (state_q == ST_RUN) && (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Nibble mux and the shared adder slice
  // ---------------------------------------------------------------------------
  assign nib_lsb = NIBBLE * 32'(idx_q);
  assign a_nib   = a_q[nib_lsb +: NIBBLE];
  assign b_nib   = b_q[nib_lsb +: NIBBLE];

  ripple_carry_4_bit_adder u_slice (
    .A  (a_nib),
    .B  (b_nib),
    .C0 (carry_q),
    .S  (s_nib),
    .C4 (c4)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up exactly with
  // the state they describe, without a combinational decode on the outputs.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: operand registers are reset along with the rest even though their
  // value is don't-care until the next accept; it keeps the block free of X
  // after reset at negligible cost for registers this narrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      // Subtraction as a + ~b + 1: invert B here, force the first carry to 1.
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      sum_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      sum_q[nib_lsb +: NIBBLE] <= s_nib;
      carry_q                  <= c4;
      if (last_step) begin
        idx_q  <= '0;
        cout_q <= c4;
        // s_nib[MSB] is the final sum's sign bit at this step.
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (s_nib[NIBBLE-1] != a_q[WIDTH-1]);
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               done_cyc;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   busy_len = 0;
  logic last_cout = 1'b0;
  logic last_ovf  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tcin, input logic tsub);
    exp_t e;
    int   full;
    int   sr;
    if (tsub) begin
      e.sum  = ta - tb;
      e.cout = (ta >= tb);
      sr     = int'($signed(ta)) - int'($signed(tb));
    end else begin
      full   = int'(ta) + int'(tb) + int'(tcin);
      e.sum  = WIDTH'(full);
      e.cout = (full >= (1 << WIDTH));
      sr     = int'($signed(ta)) + int'($signed(tb)) + int'(tcin);
    end
    e.ovf = (sr > (2**(WIDTH-1)) - 1) || (sr < -(2**(WIDTH-1)));
    e.done_cyc = 0;
    e.tag = "";
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_len++;
      else      busy_len = 0;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_sum"},  32'(sum),  32'(e.sum));
          check({e.tag, "_cout"}, 32'(cout), 32'(e.cout));
          check({e.tag, "_ovf"},  32'(ovf),  32'(e.ovf));
          check({e.tag, "_latency"}, 32'(cyc), 32'(e.done_cyc));
          check({e.tag, "_busy_len"}, 32'(busy_len), 32'(NIB + 1));
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'(busy), 32'h0);
  endtask

  // Issues one operation; checks acceptance-time side effects and queues the
  // expected result (unless the operation is going to be aborted).
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tcin, input logic tsub, input bit expect_done);
    exp_t e;
    wait_idle();
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    e = model(ta, tb, tcin, tsub);
    e.tag = tag;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands must not be resampled after acceptance.
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check({tag, "_accept_sum_clr"}, 32'(sum),  32'h0);
    check({tag, "_accept_cout_hold"}, 32'(cout), 32'(last_cout));
    check({tag, "_accept_ovf_hold"},  32'(ovf),  32'(last_ovf));
    if (expect_done) begin
      e.done_cyc = cyc + NIB;
      sb.push_back(e);
      last_cout = e.cout;
      last_ovf  = e.ovf;
    end
  endtask

  initial begin
    exp_t e;
    int   guard;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sum",  32'(sum),  32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_ovf",  32'(ovf),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op("t1_5a5a", 16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 1);
    do_op("t2_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
    do_op("t3_sub_a_gt_b", 16'h000A, 16'h0005, 1'b0, 1'b1, 1);
    do_op("t3_sub_a_lt_b", 16'h0005, 16'h000A, 1'b1, 1'b1, 1);
    do_op("t4_add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    do_op("t4_sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    do_op("sub_equal", 16'h3C3C, 16'h3C3C, 1'b0, 1'b1, 1);

    // Start pulse during RUN is ignored
    do_op("t5_ignore", 16'h1234, 16'h1111, 1'b0, 1'b0, 1);
    @(negedge clk);
    a = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held high re-triggers on the first IDLE cycle
    wait_idle();
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    e.tag = "held_1"; e.done_cyc = cyc + NIB;
    sb.push_back(e);
    repeat (NIB + 2) @(posedge clk);
    #1;
    start = 1'b0;
    e.tag = "held_2"; e.done_cyc = cyc + NIB;
    sb.push_back(e);
    last_cout = e.cout; last_ovf = e.ovf;

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rs;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
      rs = 1'($urandom);
      do_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), rs, 1);
    end

    // Reset mid-run: leave a cout=1 result first so the clear is visible
    do_op("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    do_op("aborted", 16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_sum",  32'(sum),  32'h0);
    check("t6_rst_cout", 32'(cout), 32'h0);
    check("t6_rst_ovf",  32'(ovf),  32'h0);
    last_cout = 1'b0; last_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op("t6_after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 1);

    // Drain
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(sb.size()), 32'h0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nibble_serial_adder_ctrl
